// File: rtl/crypto_regbank_pkg.sv
// Shared definitions for the Avalon crypto register bank: FSM states,
// CTRL/STATUS bit positions and register-map offset helpers.
package crypto_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } rb_state_t;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bit positions
  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_LOCKERR = 2;
  localparam int STAT_TMO     = 3;

  // Key block always starts at word 0; the argument keeps all helpers uniform.
  function automatic int key_base(input int w);
    return 0 * w;
  endfunction

  function automatic int in_base(input int w);
    return w;
  endfunction

  function automatic int out_base(input int w);
    return 2 * w;
  endfunction

  function automatic int ctrl_addr(input int w);
    return 3 * w;
  endfunction

  function automatic int status_addr(input int w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/avalon_crypto_regbank.sv
// Avalon-MM slave register bank in front of a W-word block-cipher core.
// Holds key/input words, launches the core with a one-cycle start pulse,
// captures the result on completion and reports DONE/BUSY/LOCKERR/TMO.
module avalon_crypto_regbank
  import crypto_regbank_pkg::*;
#(
  parameter int WORDS       = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int ADDR_W      = $clog2(3 * WORDS + 2)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic                  AVL_CS,
  input  logic [3:0]            AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]     AVL_ADDR,
  input  logic [31:0]           AVL_WRITEDATA,
  output logic [31:0]           AVL_READDATA,
  output logic                  AVL_IRQ,
  output logic [31:0]           EXPORT_DATA,
  output logic                  CORE_START,
  output logic                  CORE_ABORT,
  input  logic                  CORE_DONE,
  output logic [32*WORDS-1:0]   CORE_KEY,
  output logic [32*WORDS-1:0]   CORE_IN,
  input  logic [32*WORDS-1:0]   CORE_RESULT
);

  // The wait counter only has to reach TIMEOUT_CYC-1, so it never wraps
  // while the timeout is enabled; with timeout disabled its value is unused.
  localparam int               CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit               TMO_EN   = (TIMEOUT_CYC > 0);

  rb_state_t         state, state_nxt;
  logic [31:0]       key_r [WORDS];
  logic [31:0]       in_r  [WORDS];
  logic [31:0]       out_r [WORDS];
  logic              irq_en_r, done_r, lockerr_r, tmo_r, abort_r;
  logic [CNT_W-1:0]  wait_cnt;

  logic [31:0]       addr_w;
  logic [31:0]       rd_data;
  logic              wr_req, rd_req;
  logic              sel_key, sel_in, sel_ctrl, sel_status;
  logic              busy, start_wr, launch, done_hit, tmo_hit, lock_viol, status_clr;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  assign addr_w     = 32'(AVL_ADDR);
  assign wr_req     = AVL_CS & AVL_WRITE;
  // A combined read+write performs only the write; READDATA keeps its value.
  assign rd_req     = AVL_CS & AVL_READ & ~AVL_WRITE;
  assign sel_key    = addr_w < 32'(in_base(WORDS));
  assign sel_in     = (addr_w >= 32'(in_base(WORDS))) && (addr_w < 32'(out_base(WORDS)));
  assign sel_ctrl   = addr_w == 32'(ctrl_addr(WORDS));
  assign sel_status = addr_w == 32'(status_addr(WORDS));

  assign busy       = (state != ST_IDLE);
  assign start_wr   = wr_req & sel_ctrl & AVL_BYTE_EN[0] & AVL_WRITEDATA[CTRL_START];
  assign launch     = start_wr & ~busy;
  assign done_hit   = (state == ST_WAIT) & CORE_DONE;
  // CORE_DONE in the terminal cycle takes priority over the abort.
  assign tmo_hit    = TMO_EN & (state == ST_WAIT) & ~CORE_DONE & (wait_cnt == CNT_TERM);
  assign lock_viol  = busy & ((wr_req & (sel_key | sel_in)) | start_wr);
  assign status_clr = wr_req & sel_status & AVL_BYTE_EN[0];

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (launch) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (done_hit || tmo_hit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: zeroed while launching, counts every WAIT cycle
  always_ff @(posedge CLK) begin
    if (RESET)                   wait_cnt <= '0;
    else if (state == ST_LAUNCH) wait_cnt <= '0;
    else if (state == ST_WAIT)   wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Key/input/result registers; key/input writes are dropped while busy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < WORDS; i++) begin
        key_r[i] <= '0;
        in_r[i]  <= '0;
        out_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (wr_req && !busy && addr_w == 32'(key_base(WORDS) + i))
          key_r[i] <= be_merge(key_r[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (wr_req && !busy && addr_w == 32'(in_base(WORDS) + i))
          in_r[i] <= be_merge(in_r[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (done_hit)
          out_r[i] <= CORE_RESULT[32*(WORDS-1-i) +: 32];
      end
    end
  end

  // Control and status bits; hardware set wins over a software clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_en_r  <= 1'b0;
      done_r    <= 1'b0;
      lockerr_r <= 1'b0;
      tmo_r     <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      abort_r <= tmo_hit;
      if (wr_req && sel_ctrl && AVL_BYTE_EN[0])
        irq_en_r <= AVL_WRITEDATA[CTRL_IRQ_EN];

      if (done_hit)
        done_r <= 1'b1;
      else if (launch || (status_clr && AVL_WRITEDATA[STAT_DONE]))
        done_r <= 1'b0;

      if (tmo_hit)
        tmo_r <= 1'b1;
      else if (status_clr && AVL_WRITEDATA[STAT_TMO])
        tmo_r <= 1'b0;

      if (lock_viol)
        lockerr_r <= 1'b1;
      else if (status_clr && AVL_WRITEDATA[STAT_LOCKERR])
        lockerr_r <= 1'b0;
    end
  end

  // Read mux over the register map; unmapped addresses read 0
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (addr_w == 32'(key_base(WORDS) + i)) rd_data = key_r[i];
      if (addr_w == 32'(in_base(WORDS) + i))  rd_data = in_r[i];
      if (addr_w == 32'(out_base(WORDS) + i)) rd_data = out_r[i];
    end
    if (sel_ctrl)
      rd_data[CTRL_IRQ_EN] = irq_en_r;
    if (sel_status) begin
      rd_data[STAT_DONE]    = done_r;
      rd_data[STAT_BUSY]    = busy;
      rd_data[STAT_LOCKERR] = lockerr_r;
      rd_data[STAT_TMO]     = tmo_r;
    end
  end

  // Registered read data with one cycle of latency
  always_ff @(posedge CLK) begin
    if (RESET)       AVL_READDATA <= '0;
    else if (rd_req) AVL_READDATA <= rd_data;
  end

  // Pack key/input words for the core, word 0 in the most significant slot
  always_comb begin
    CORE_KEY = '0;
    CORE_IN  = '0;
    for (int i = 0; i < WORDS; i++) begin
      CORE_KEY[32*(WORDS-1-i) +: 32] = key_r[i];
      CORE_IN[32*(WORDS-1-i) +: 32]  = in_r[i];
    end
  end

  assign CORE_START  = (state == ST_LAUNCH);
  assign CORE_ABORT  = abort_r;
  assign AVL_IRQ     = done_r & irq_en_r;
  assign EXPORT_DATA = {key_r[0][31:16], key_r[WORDS-1][15:0]};

endmodule

// File: tb/tb_avalon_crypto_regbank.sv
// Bench for avalon_crypto_regbank: a register-map level model checked every
// cycle on the main instance, plus directed literal checks on both instances
// (the second instance has an 8-cycle timeout).
module tb_avalon_crypto_regbank;

  localparam int W  = 4;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;

  // main instance (no timeout)
  logic          rd = 0, wr = 0, cs = 0, cdone = 0;
  logic [3:0]    be = 0;
  logic [AW-1:0] addr = 0;
  logic [31:0]   wd = 0;
  logic [127:0]  cres = 0;
  logic [31:0]   readdata, exp_data;
  logic          irq, cstart, cabort;
  logic [127:0]  ckey, cin;

  // timeout instance
  logic          t_rd = 0, t_wr = 0, t_cs = 0, t_done = 0;
  logic [3:0]    t_be = 0;
  logic [AW-1:0] t_addr = 0;
  logic [31:0]   t_wd = 0;
  logic [127:0]  t_res = 0;
  logic [31:0]   t_readdata, t_exp;
  logic          t_irq, t_start, t_abort;
  logic [127:0]  t_key, t_in;

  avalon_crypto_regbank #(.WORDS(W), .TIMEOUT_CYC(0)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(rd), .AVL_WRITE(wr), .AVL_CS(cs),
    .AVL_BYTE_EN(be), .AVL_ADDR(addr), .AVL_WRITEDATA(wd), .AVL_READDATA(readdata),
    .AVL_IRQ(irq), .EXPORT_DATA(exp_data), .CORE_START(cstart), .CORE_ABORT(cabort),
    .CORE_DONE(cdone), .CORE_KEY(ckey), .CORE_IN(cin), .CORE_RESULT(cres)
  );

  avalon_crypto_regbank #(.WORDS(W), .TIMEOUT_CYC(8)) dut_t (
    .CLK(CLK), .RESET(RESET), .AVL_READ(t_rd), .AVL_WRITE(t_wr), .AVL_CS(t_cs),
    .AVL_BYTE_EN(t_be), .AVL_ADDR(t_addr), .AVL_WRITEDATA(t_wd), .AVL_READDATA(t_readdata),
    .AVL_IRQ(t_irq), .EXPORT_DATA(t_exp), .CORE_START(t_start), .CORE_ABORT(t_abort),
    .CORE_DONE(t_done), .CORE_KEY(t_key), .CORE_IN(t_in), .CORE_RESULT(t_res)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [31:0] m_key [4];
  logic [31:0] m_in  [4];
  logic [31:0] m_out [4];
  logic [31:0] m_rd;
  bit          m_irq_en, m_done, m_lock, m_tmo, m_valid;
  int          m_age;   // 0: idle, 1: start pulse cycle, >=2: waiting on core

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = 0;
    if (a < 4)       r = m_key[a];
    else if (a < 8)  r = m_in[a-4];
    else if (a < 12) r = m_out[a-8];
    else if (a == 12) r = {30'b0, m_irq_en, 1'b0};
    else if (a == 13) r = {28'b0, m_tmo, m_lock, (m_age != 0), m_done};
    return r;
  endfunction

  always @(posedge CLK) begin : model
    logic [31:0] v;
    int a, age_n;
    bit busy, dh;
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin m_key[i] = 0; m_in[i] = 0; m_out[i] = 0; end
      m_rd = 0; m_irq_en = 0; m_done = 0; m_lock = 0; m_tmo = 0; m_age = 0;
      m_valid = 1;
    end else if (m_valid) begin
      a     = int'(addr);
      busy  = (m_age != 0);
      dh    = (m_age >= 2) && cdone;
      age_n = m_age;
      if (m_age == 1) age_n = 2;
      else if (dh)    age_n = 0;
      if (cs && rd && !wr) m_rd = m_read(a);
      if (cs && wr) begin
        if (a < 8) begin
          if (busy) m_lock = 1;
          else begin
            if (a < 4) v = m_key[a]; else v = m_in[a-4];
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
            if (a < 4) m_key[a] = v; else m_in[a-4] = v;
          end
        end else if (a == 12 && be[0]) begin
          m_irq_en = wd[1];
          if (wd[0]) begin
            if (busy) m_lock = 1;
            else begin m_done = 0; age_n = 1; end
          end
        end else if (a == 13 && be[0]) begin
          if (wd[0]) m_done = 0;
          if (wd[2]) m_lock = 0;
          if (wd[3]) m_tmo  = 0;
        end
      end
      if (dh) begin
        for (int i = 0; i < 4; i++) m_out[i] = cres[32*(3-i) +: 32];
        m_done = 1;
      end
      m_age = age_n;
    end
  end

  // per-cycle comparison of the main instance against the model
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("readdata", readdata, m_rd);
      chk("irq", irq, m_done & m_irq_en);
      chk("core_start", cstart, m_age == 1);
      chk("core_abort", cabort, 1'b0);
      chk("core_key", ckey, {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("core_in", cin, {m_in[0], m_in[1], m_in[2], m_in[3]});
      chk("export", exp_data, {m_key[0][31:16], m_key[3][15:0]});
      if (cstart) n_start++;
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1; wr = 1; addr = a; wd = d; be = b;
    @(negedge CLK);
    cs = 0; wr = 0; be = 0;
  endtask

  task automatic rd0(input logic [AW-1:0] a, output logic [31:0] d);
    cs = 1; rd = 1; addr = a;
    @(negedge CLK);
    d = readdata;
    cs = 0; rd = 0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    t_cs = 1; t_wr = 1; t_addr = a; t_wd = d; t_be = b;
    @(negedge CLK);
    t_cs = 0; t_wr = 0; t_be = 0;
  endtask

  task automatic rd1(input logic [AW-1:0] a, output logic [31:0] d);
    t_cs = 1; t_rd = 1; t_addr = a;
    @(negedge CLK);
    d = t_readdata;
    t_cs = 0; t_rd = 0;
  endtask

  logic [31:0] kw [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

  initial begin
    logic [31:0] d;
    int first_k, n_ab;

    // reset, then every address reads 0
    repeat (3) @(negedge CLK);
    RESET = 0;
    chk("reset_export", exp_data, 32'h0);
    chk("reset_irq", irq, 1'b0);
    for (int a = 0; a < 16; a++) begin
      rd0(AW'(a), d);
      chk("reset_read", d, 32'h0);
    end
    rd1(4'd13, d);
    chk("t_reset_status", d, 32'h0);

    // key load and partial byte-enable overwrite
    for (int i = 0; i < 4; i++) wr0(AW'(i), kw[i], 4'hF);
    wr0(4'd1, 32'h00AA0000, 4'b0100);
    rd0(4'd1, d);
    chk("key1_be", d, 32'h04AA0607);
    chk("core_key_msw", ckey[127:96], 32'h00010203);
    chk("export_keys", exp_data, 32'h00010E0F);
    wr0(4'd4, 32'h11111111, 4'hF);
    wr0(4'd5, 32'h22222222, 4'hF);

    // IRQ enable; a CTRL write without byte 0 is ignored
    wr0(4'd12, 32'h2, 4'hF);
    wr0(4'd12, 32'h0, 4'b0010);
    rd0(4'd12, d);
    chk("ctrl_irq_en", d, 32'h2);

    // launch, then lock violations while busy
    wr0(4'd12, 32'h3, 4'h1);                 // edge t
    chk("start_pulse", cstart, 1'b1);
    rd0(4'd13, d);                           // t+1
    chk("status_busy", d, 32'h2);
    wr0(4'd4, 32'h12345678, 4'hF);           // t+2
    wr0(4'd12, 32'h3, 4'h1);                 // t+3
    rd0(4'd4, d);                            // t+4
    chk("in0_locked", d, 32'h11111111);
    rd0(4'd13, d);                           // t+5
    chk("status_lockerr", d, 32'h6);
    repeat (4) @(negedge CLK);
    cres  = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    cdone = 1;
    @(negedge CLK);                          // sampled at t+10
    cdone = 0;
    chk("irq_on_done", irq, 1'b1);
    chk("start_count1", n_start, 1);
    rd0(4'd8, d);
    chk("out0", d, 32'hDEADBEEF);
    rd0(4'd11, d);
    chk("out3", d, 32'h89ABCDEF);
    rd0(4'd13, d);
    chk("status_done", d, 32'h5);
    wr0(4'd13, 32'h1, 4'h1);
    chk("irq_cleared", irq, 1'b0);
    rd0(4'd13, d);
    chk("status_after_clr", d, 32'h4);
    wr0(4'd13, 32'h4, 4'h1);
    rd0(4'd13, d);
    chk("status_clean", d, 32'h0);

    // software DONE clear in the same cycle the core completes
    cres = {4{32'hA5A5A5A5}};
    wr0(4'd12, 32'h3, 4'h1);
    @(negedge CLK);
    cs = 1; wr = 1; addr = 4'd13; wd = 32'h1; be = 4'h1; cdone = 1;
    @(negedge CLK);
    cs = 0; wr = 0; be = 0; cdone = 0;
    rd0(4'd13, d);
    chk("done_set_wins", d, 32'h1);
    chk("start_count2", n_start, 2);
    rd0(4'd8, d);
    chk("out0_second", d, 32'hA5A5A5A5);

    // timeout instance: one normal completion, then a run that never finishes
    t_res = {32'h13579BDF, 32'h0, 32'h0, 32'h0};
    wr1(4'd12, 32'h1, 4'h1);
    @(negedge CLK);
    t_done = 1;
    @(negedge CLK);
    t_done = 0;
    rd1(4'd13, d);
    chk("t_status_done", d, 32'h1);
    wr1(4'd12, 32'h1, 4'h1);                 // edge t
    chk("t_start_pulse", t_start, 1'b1);
    first_k = -1;
    n_ab    = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (t_abort) begin
        if (first_k < 0) first_k = k;
        n_ab++;
      end
    end
    chk("t_abort_cycle", 32'(first_k), 32'd9);
    chk("t_abort_count", 32'(n_ab), 32'd1);
    rd1(4'd13, d);
    chk("t_status_tmo", d, 32'h8);
    rd1(4'd8, d);
    chk("t_out_unchanged", d, 32'h13579BDF);

    // reset in the middle of a WAIT
    wr0(4'd12, 32'h1, 4'h1);
    repeat (2) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    chk("rst_abort", cabort, 1'b0);
    chk("rst_start", cstart, 1'b0);
    chk("rst_export", exp_data, 32'h0);
    for (int a = 0; a < 16; a++) begin
      rd0(AW'(a), d);
      chk("midrst_read", d, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
